// File: rtl/pir_alarm_ctrl.sv
// PIR alarm sequencer: arm/disarm with exit delay, camera capture req/ack,
// patterned buzzer/LED alarm, cooldown, and status/IRQ toward the PS.
module pir_alarm_ctrl #(
    parameter int TICK_DIV      = 100000,
    parameter int ARM_DELAY_T   = 5000,
    parameter int CAP_TIMEOUT_T = 200,
    parameter int ALARM_T       = 10000,
    parameter int BEEP_T        = 250,
    parameter int COOLDOWN_T    = 2000,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arm,
    input  logic             disarm,
    input  logic             motion,
    input  logic             ack,
    input  logic             clr_stat,
    input  logic             cap_ack,
    output logic             cap_req,
    output logic             led,
    output logic             buzzer,
    output logic             alarm_active,
    output logic             irq,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] event_cnt,
    output logic             cap_err
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [31:0]   ARM_LAST   = 32'(ARM_DELAY_T - 1);
    localparam logic [31:0]   CAP_LAST   = 32'(CAP_TIMEOUT_T - 1);
    localparam logic [31:0]   ALARM_LAST = 32'(ALARM_T - 1);
    localparam logic [31:0]   BEEP_LAST  = 32'(BEEP_T - 1);
    localparam logic [31:0]   COOL_LAST  = 32'(COOLDOWN_T - 1);

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_ARMING   = 3'd1,
        S_ARMED    = 3'd2,
        S_CAPTURE  = 3'd3,
        S_ALARM    = 3'd4,
        S_COOLDOWN = 3'd5
    } state_t;

    state_t        st;
    logic [PW-1:0] presc;
    logic [31:0]   timer;
    logic [31:0]   beep_cnt;
    logic          tick;
    logic          motion_q;
    logic          motion_rise;
    logic          disarm_pend;
    logic          cap_timeout;
    logic          cnt_inc;
    logic          alarm_exit;

    assign state       = st;
    assign tick        = (presc == PRESC_LAST);
    assign motion_rise = motion & ~motion_q;
    assign cap_timeout = (st == S_CAPTURE) && tick && (timer == CAP_LAST) && !cap_ack;
    assign alarm_exit  = ack || (!motion_rise && tick && (timer == ALARM_LAST));

    // A motion edge is only counted when the FSM actually acts on it; in CAPTURE
    // a pending disarm does not suppress the count.
    assign cnt_inc = motion_rise &&
                     ((st == S_CAPTURE) ||
                      (!disarm && ((st == S_ARMED) || ((st == S_ALARM) && !ack))));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            motion_q <= 1'b0;
        end else begin
            presc    <= tick ? '0 : presc + PW'(1);
            motion_q <= motion;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st           <= S_DISARMED;
            timer        <= '0;
            beep_cnt     <= '0;
            disarm_pend  <= 1'b0;
            cap_req      <= 1'b0;
            led          <= 1'b0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            irq          <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (tick) timer <= timer + 32'd1;

            // Disarm during CAPTURE must not withdraw cap_req, so it is deferred.
            if (disarm && (st != S_CAPTURE)) begin
                st           <= S_DISARMED;
                timer        <= '0;
                beep_cnt     <= '0;
                disarm_pend  <= 1'b0;
                cap_req      <= 1'b0;
                led          <= 1'b0;
                buzzer       <= 1'b0;
                alarm_active <= 1'b0;
            end else begin
                case (st)
                    S_DISARMED: begin
                        if (arm) begin
                            st    <= S_ARMING;
                            timer <= '0;
                        end
                    end
                    S_ARMING: begin
                        if (tick && (timer == ARM_LAST)) begin
                            st    <= S_ARMED;
                            timer <= '0;
                        end
                    end
                    S_ARMED: begin
                        if (motion_rise) begin
                            st          <= S_CAPTURE;
                            timer       <= '0;
                            cap_req     <= 1'b1;
                            disarm_pend <= 1'b0;
                        end
                    end
                    S_CAPTURE: begin
                        if (disarm) disarm_pend <= 1'b1;
                        if (cap_ack || cap_timeout) begin
                            cap_req     <= 1'b0;
                            timer       <= '0;
                            disarm_pend <= 1'b0;
                            if (disarm_pend || disarm) begin
                                st <= S_DISARMED;
                            end else begin
                                st           <= S_ALARM;
                                irq          <= 1'b1;
                                alarm_active <= 1'b1;
                                led          <= 1'b1;
                                buzzer       <= 1'b1;
                                beep_cnt     <= '0;
                            end
                        end
                    end
                    S_ALARM: begin
                        if (alarm_exit) begin
                            st           <= S_COOLDOWN;
                            timer        <= '0;
                            led          <= 1'b0;
                            buzzer       <= 1'b0;
                            alarm_active <= 1'b0;
                        end else if (motion_rise) begin
                            timer    <= '0;
                            beep_cnt <= '0;
                            buzzer   <= 1'b1;
                        end else if (tick) begin
                            if (beep_cnt == BEEP_LAST) begin
                                beep_cnt <= '0;
                                buzzer   <= ~buzzer;
                            end else begin
                                beep_cnt <= beep_cnt + 32'd1;
                            end
                        end
                    end
                    S_COOLDOWN: begin
                        if (tick && (timer == COOL_LAST)) begin
                            st    <= S_ARMED;
                            timer <= '0;
                        end
                    end
                    default: begin
                        st           <= S_DISARMED;
                        timer        <= '0;
                        beep_cnt     <= '0;
                        disarm_pend  <= 1'b0;
                        cap_req      <= 1'b0;
                        led          <= 1'b0;
                        buzzer       <= 1'b0;
                        alarm_active <= 1'b0;
                    end
                endcase
            end
        end
    end

    // clr_stat has priority over a coincident increment or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_cnt <= '0;
            cap_err   <= 1'b0;
        end else if (clr_stat) begin
            event_cnt <= '0;
            cap_err   <= 1'b0;
        end else begin
            if (cnt_inc && (event_cnt != {CNT_W{1'b1}})) event_cnt <= event_cnt + CNT_W'(1);
            if (cap_timeout) cap_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pir_alarm_ctrl.sv
// Self-checking bench for pir_alarm_ctrl: directed scenarios plus a randomized
// run compared against a countdown-style behavioural model.
module tb_pir_alarm_ctrl;

    localparam int ARM_D = 3;
    localparam int CAP_T = 4;
    localparam int ALM_T = 10;
    localparam int BEEP  = 2;
    localparam int COOL  = 6;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arm = 1'b0, disarm = 1'b0, motion = 1'b0, ack = 1'b0, clr_stat = 1'b0, cap_ack = 1'b0;
    logic cap_req, led, buzzer, alarm_active, irq, cap_err;
    logic [2:0] state;
    logic [CW-1:0] event_cnt;

    logic arm2 = 1'b0;
    logic cap_req2, led2, buzzer2, alarm_active2, irq2, cap_err2;
    logic [2:0] state2;
    logic [15:0] event_cnt2;

    int errors = 0;
    int checks = 0;

    pir_alarm_ctrl #(
        .TICK_DIV(1), .ARM_DELAY_T(ARM_D), .CAP_TIMEOUT_T(CAP_T), .ALARM_T(ALM_T),
        .BEEP_T(BEEP), .COOLDOWN_T(COOL), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .disarm(disarm), .motion(motion), .ack(ack),
        .clr_stat(clr_stat), .cap_ack(cap_ack), .cap_req(cap_req), .led(led), .buzzer(buzzer),
        .alarm_active(alarm_active), .irq(irq), .state(state), .event_cnt(event_cnt), .cap_err(cap_err)
    );

    pir_alarm_ctrl #(
        .TICK_DIV(4), .ARM_DELAY_T(2), .CAP_TIMEOUT_T(4), .ALARM_T(10),
        .BEEP_T(2), .COOLDOWN_T(6), .CNT_W(16)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .arm(arm2), .disarm(1'b0), .motion(1'b0), .ack(1'b0),
        .clr_stat(1'b0), .cap_ack(1'b0), .cap_req(cap_req2), .led(led2), .buzzer(buzzer2),
        .alarm_active(alarm_active2), .irq(irq2), .state(state2), .event_cnt(event_cnt2), .cap_err(cap_err2)
    );

    initial forever #5 clk = ~clk;

    // Reference model: phases by name-code, each timed phase counts remaining ticks down.
    int m_phase, m_left, m_beep, m_cnt;
    bit m_req, m_led, m_buz, m_act, m_irq, m_err, m_pend, m_prev, m_rise, m_inc, m_to;

    task automatic model_cool();
        m_phase = 5; m_left = COOL; m_led = 0; m_buz = 0; m_act = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_left = 0; m_beep = 0; m_cnt = 0;
            m_req = 0; m_led = 0; m_buz = 0; m_act = 0; m_irq = 0; m_err = 0; m_pend = 0; m_prev = 0;
        end else begin
            m_rise = motion && !m_prev;
            m_prev = motion;
            m_irq = 0; m_inc = 0; m_to = 0;
            if (disarm && m_phase != 3) begin
                m_phase = 0; m_req = 0; m_led = 0; m_buz = 0; m_act = 0; m_pend = 0;
            end else begin
                case (m_phase)
                    0: if (arm) begin m_phase = 1; m_left = ARM_D; end
                    1: begin m_left--; if (m_left == 0) m_phase = 2; end
                    2: if (m_rise) begin m_phase = 3; m_left = CAP_T; m_req = 1; m_inc = 1; m_pend = 0; end
                    3: begin
                        m_inc = m_rise;
                        if (disarm) m_pend = 1;
                        m_left--;
                        if (cap_ack || m_left == 0) begin
                            m_to = !cap_ack;
                            m_req = 0;
                            if (m_pend) m_phase = 0;
                            else begin
                                m_phase = 4; m_irq = 1; m_act = 1; m_led = 1; m_buz = 1;
                                m_left = ALM_T; m_beep = BEEP;
                            end
                            m_pend = 0;
                        end
                    end
                    4: begin
                        if (ack) model_cool();
                        else if (m_rise) begin m_inc = 1; m_left = ALM_T; m_beep = BEEP; m_buz = 1; end
                        else begin
                            m_left--;
                            if (m_left == 0) model_cool();
                            else begin
                                m_beep--;
                                if (m_beep == 0) begin m_buz = !m_buz; m_beep = BEEP; end
                            end
                        end
                    end
                    5: begin m_left--; if (m_left == 0) m_phase = 2; end
                    default: m_phase = 0;
                endcase
            end
            if (clr_stat) begin m_cnt = 0; m_err = 0; end
            else begin
                if (m_inc && m_cnt < (1 << CW) - 1) m_cnt++;
                if (m_to) m_err = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        repeat (2) step();
        got = {state, cap_req, led, buzzer, alarm_active, irq, cap_err, event_cnt};
        checks++; if (got !== 14'd0) begin errors++; $display("[TB] FAIL reset_outputs: got %h expected 0", got); end
        checks++; if (state2 !== 3'd0 || cap_req2 !== 1'b0 || event_cnt2 !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_dut2: got state=%0d req=%0d cnt=%0d expected 0", state2, cap_req2, event_cnt2);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_arm();
        arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k < ARM_D; k++) begin
            checks++; if (state !== 3'd1) begin errors++; $display("[TB] FAIL arming_state[%0d]: got %0d expected 1", k, state); end
            motion = (k == 0);
            step();
        end
        motion = 1'b0;
        checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL armed_state: got %0d expected 2", state); end
        checks++; if (event_cnt !== '0) begin errors++; $display("[TB] FAIL arming_motion_cnt: got %0d expected 0", event_cnt); end
    endtask

    task automatic test_capture();
        motion = 1'b1; step();
        checks++; if (state !== 3'd3 || cap_req !== 1'b1) begin
            errors++; $display("[TB] FAIL capture_entry: got state=%0d req=%0d expected 3/1", state, cap_req);
        end
        checks++; if (event_cnt !== 4'd1) begin errors++; $display("[TB] FAIL capture_cnt: got %0d expected 1", event_cnt); end
        for (int k = 0; k < 2; k++) begin
            step();
            checks++; if (cap_req !== 1'b1 || state !== 3'd3) begin
                errors++; $display("[TB] FAIL capture_hold[%0d]: got state=%0d req=%0d expected 3/1", k, state, cap_req);
            end
        end
        cap_ack = 1'b1; step(); cap_ack = 1'b0;
        checks++; if ({state, cap_req, irq, alarm_active, led, buzzer} !== {3'd4, 5'b01111}) begin
            errors++; $display("[TB] FAIL alarm_entry: got st=%0d req=%0d irq=%0d act=%0d led=%0d buz=%0d expected 4/0/1/1/1/1",
                               state, cap_req, irq, alarm_active, led, buzzer);
        end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_one_cycle: got %0d expected 0", irq); end
    endtask

    task automatic test_alarm_pattern();
        logic exp_buz;
        motion = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            exp_buz = ((k / 2) % 2) == 0;
            checks++; if (buzzer !== exp_buz || state !== 3'd4) begin
                errors++; $display("[TB] FAIL beep[%0d]: got buz=%0d st=%0d expected %0d/4", k, buzzer, state, exp_buz);
            end
            step();
        end
        motion = 1'b1;
        step();
        checks++; if (buzzer !== 1'b1 || state !== 3'd4 || event_cnt !== 4'd2 || irq !== 1'b0) begin
            errors++; $display("[TB] FAIL retrigger: got buz=%0d st=%0d cnt=%0d irq=%0d expected 1/4/2/0", buzzer, state, event_cnt, irq);
        end
        for (int j = 1; j < ALM_T; j++) begin
            step();
            exp_buz = ((j / 2) % 2) == 0;
            checks++; if (buzzer !== exp_buz || state !== 3'd4) begin
                errors++; $display("[TB] FAIL retrig_beep[%0d]: got buz=%0d st=%0d expected %0d/4", j, buzzer, state, exp_buz);
            end
        end
        step();
        checks++; if ({state, led, buzzer, alarm_active} !== {3'd5, 3'b000}) begin
            errors++; $display("[TB] FAIL cooldown_entry: got st=%0d led=%0d buz=%0d act=%0d expected 5/0/0/0", state, led, buzzer, alarm_active);
        end
        for (int c = 1; c < COOL; c++) step();
        checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL cooldown_hold: got %0d expected 5", state); end
        step();
        checks++; if (state !== 3'd2) begin errors++; $display("[TB] FAIL rearm: got %0d expected 2", state); end
    endtask

    task automatic test_timeout();
        motion = 1'b0; step();
        motion = 1'b1; step();
        for (int k = 1; k < CAP_T; k++) begin
            step();
            checks++; if (state !== 3'd3 || cap_req !== 1'b1) begin
                errors++; $display("[TB] FAIL timeout_wait[%0d]: got st=%0d req=%0d expected 3/1", k, state, cap_req);
            end
        end
        step();
        checks++; if ({state, cap_err, irq, cap_req} !== {3'd4, 3'b110}) begin
            errors++; $display("[TB] FAIL timeout_alarm: got st=%0d err=%0d irq=%0d req=%0d expected 4/1/1/0", state, cap_err, irq, cap_req);
        end
        ack = 1'b1; step(); ack = 1'b0;
        checks++; if (state !== 3'd5) begin errors++; $display("[TB] FAIL ack_cooldown: got %0d expected 5", state); end
        disarm = 1'b1; step(); disarm = 1'b0;
        checks++; if (state !== 3'd0 || cap_err !== 1'b1 || event_cnt !== 4'd3) begin
            errors++; $display("[TB] FAIL disarm_keep_stats: got st=%0d err=%0d cnt=%0d expected 0/1/3", state, cap_err, event_cnt);
        end
        motion = 1'b0;
    endtask

    task automatic test_pending_disarm();
        arm = 1'b1; step(); arm = 1'b0;
        repeat (ARM_D) step();
        motion = 1'b1; step();
        disarm = 1'b1; step(); disarm = 1'b0;
        checks++; if (state !== 3'd3 || cap_req !== 1'b1) begin
            errors++; $display("[TB] FAIL pend_hold: got st=%0d req=%0d expected 3/1", state, cap_req);
        end
        step();
        cap_ack = 1'b1; step(); cap_ack = 1'b0;
        checks++; if ({state, irq, cap_req, alarm_active} !== {3'd0, 3'b000}) begin
            errors++; $display("[TB] FAIL pend_disarmed: got st=%0d irq=%0d req=%0d act=%0d expected 0/0/0/0", state, irq, cap_req, alarm_active);
        end
        step();
        checks++; if (irq !== 1'b0 || event_cnt !== 4'd4) begin
            errors++; $display("[TB] FAIL pend_no_irq: got irq=%0d cnt=%0d expected 0/4", irq, event_cnt);
        end
        motion = 1'b0;
    endtask

    task automatic test_priority();
        arm = 1'b1; disarm = 1'b1; step(); arm = 1'b0; disarm = 1'b0;
        checks++; if (state !== 3'd0) begin errors++; $display("[TB] FAIL arm_disarm_same: got %0d expected 0", state); end
        arm = 1'b1; step(); arm = 1'b0;
        repeat (ARM_D) step();
        motion = 1'b1; clr_stat = 1'b1; step(); clr_stat = 1'b0;
        checks++; if (state !== 3'd3 || event_cnt !== '0 || cap_err !== 1'b0) begin
            errors++; $display("[TB] FAIL clr_with_motion: got st=%0d cnt=%0d err=%0d expected 3/0/0", state, event_cnt, cap_err);
        end
        cap_ack = 1'b1; step(); cap_ack = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            motion = 1'b0; step();
            motion = 1'b1; step();
            if (i == 13) begin
                checks++; if (event_cnt !== 4'd14) begin errors++; $display("[TB] FAIL cnt_count: got %0d expected 14", event_cnt); end
            end
        end
        checks++; if (event_cnt !== 4'd15 || state !== 3'd4) begin
            errors++; $display("[TB] FAIL cnt_saturate: got cnt=%0d st=%0d expected 15/4", event_cnt, state);
        end
        clr_stat = 1'b1; step(); clr_stat = 1'b0;
        checks++; if (event_cnt !== '0) begin errors++; $display("[TB] FAIL clr_stat: got %0d expected 0", event_cnt); end
        disarm = 1'b1; step(); disarm = 1'b0;
        checks++; if ({state, led, buzzer, alarm_active} !== {3'd0, 3'b000}) begin
            errors++; $display("[TB] FAIL alarm_disarm: got st=%0d led=%0d buz=%0d act=%0d expected 0", state, led, buzzer, alarm_active);
        end
        motion = 1'b0; step();
    endtask

    task automatic test_prescaler();
        int n;
        arm2 = 1'b1; step(); arm2 = 1'b0;
        n = 0;
        while (state2 == 3'd1 && n < 20) begin step(); n++; end
        checks++; if (n < 5 || n > 8) begin errors++; $display("[TB] FAIL prescaled_arming: got %0d cycles expected 5..8", n); end
        checks++; if (state2 !== 3'd2) begin errors++; $display("[TB] FAIL prescaled_armed: got %0d expected 2", state2); end
    endtask

    task automatic test_reset_mid();
        logic [13:0] got;
        arm = 1'b1; step(); arm = 1'b0;
        repeat (ARM_D) step();
        motion = 1'b1; step();
        checks++; if (cap_req !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_req: got %0d expected 1", cap_req); end
        rst_n = 1'b0;
        #1;
        got = {state, cap_req, led, buzzer, alarm_active, irq, cap_err, event_cnt};
        checks++; if (got !== 14'd0) begin errors++; $display("[TB] FAIL async_reset: got %h expected 0", got); end
        checks++; if (state2 !== 3'd0) begin errors++; $display("[TB] FAIL async_reset_dut2: got %0d expected 0", state2); end
        motion = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [13:0] got, exp;
        for (int i = 0; i < 2000; i++) begin
            arm      = ($urandom_range(0, 7) == 0);
            disarm   = ($urandom_range(0, 79) == 0);
            ack      = ($urandom_range(0, 29) == 0);
            clr_stat = ($urandom_range(0, 99) == 0);
            cap_ack  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) motion = ~motion;
            step();
            got = {state, cap_req, led, buzzer, alarm_active, irq, cap_err, event_cnt};
            exp = {3'(m_phase), m_req, m_led, m_buz, m_act, m_irq, m_err, CW'(m_cnt)};
            checks++; if (got !== exp) begin
                errors++; $display("[TB] FAIL random[%0d]: got %b expected %b", i, got, exp);
            end
        end
        arm = 0; disarm = 0; ack = 0; clr_stat = 0; cap_ack = 0; motion = 0;
    endtask

    initial begin
        test_reset();
        test_arm();
        test_capture();
        test_alarm_pattern();
        test_timeout();
        test_pending_disarm();
        test_priority();
        test_saturation();
        test_prescaler();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
